memory_access: RTL and testbench

Memory-access stage of the in-order RV64 pipeline, sitting between the E/M pipeline register and the M/W pipeline register. It decodes the registered load/store info, drives the data-cache request/response handshake, aligns store data and strobes, and aligns and extends load data. It stalls upstream while a cache access is outstanding. It owns its own output register toward writeback.

---
 rtl/memory_pkg.sv | 42 ++++
 rtl/memory_access_load_store_align.sv | 93 +++++++++
 rtl/memory_access.sv | 183 ++++++++++++++++++
 tb/tb_memory_access.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the memory-access stage: widths, load/store decode
// indices, access sizes and the request FSM states.
package memory_pkg;

    localparam int XLEN     = 64;
    localparam int COMMIT_W = 161;
    localparam int LSI_W    = 11;
    localparam int OPC_W    = 12;
    localparam int RD_W     = 5;

    localparam int LSI_LB  = 0;
    localparam int LSI_LH  = 1;
    localparam int LSI_LW  = 2;
    localparam int LSI_LD  = 3;
    localparam int LSI_LBU = 4;
    localparam int LSI_LHU = 5;
    localparam int LSI_LWU = 6;
    localparam int LSI_SB  = 7;
    localparam int LSI_SH  = 8;
    localparam int LSI_SW  = 9;
    localparam int LSI_SD  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } access_size_e;

    // Isolates the lowest set bit so a malformed multi-hot decode still
    // resolves to exactly one operation.
    function automatic logic [LSI_W-1:0] lowest_one(input logic [LSI_W-1:0] v);
        return v & (~v + {{(LSI_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/memory_access_load_store_align.sv
// Combinational lane logic: store data/strobe placement, load lane extraction
// with sign/zero extension, and misalignment detection.
module load_store_align
    import memory_pkg::*;
(
    input  logic [LSI_W-1:0] i_lsi,
    input  logic [XLEN-1:0]  i_addr,
    input  logic [XLEN-1:0]  i_regdata2,
    input  logic [XLEN-1:0]  i_rdata,
    output logic             o_mem_op,
    output logic             o_is_load,
    output logic             o_is_store,
    output logic             o_misalign,
    output logic [XLEN-1:0]  o_wdata,
    output logic [7:0]       o_wstrb,
    output logic [XLEN-1:0]  o_load_data
);

    logic [LSI_W-1:0] w_sel;
    access_size_e     w_size;
    logic             w_signed;
    logic [2:0]       w_off;
    logic [5:0]       w_shamt;
    logic [XLEN-1:0]  w_rep;
    logic [7:0]       w_strb_base;
    logic [XLEN-1:0]  w_lane;
    logic             w_size_misalign;

    assign w_sel      = lowest_one(i_lsi);
    assign o_mem_op   = |i_lsi;
    assign o_is_load  = |w_sel[LSI_LWU:LSI_LB];
    assign o_is_store = |w_sel[LSI_SD:LSI_SB];
    assign w_off      = i_addr[2:0];
    assign w_shamt    = {w_off, 3'b000};
    assign w_signed   = w_sel[LSI_LB] | w_sel[LSI_LH] | w_sel[LSI_LW];

    always_comb begin
        w_size = SZ_B;
        if (w_sel[LSI_LH] | w_sel[LSI_LHU] | w_sel[LSI_SH]) begin
            w_size = SZ_H;
        end else if (w_sel[LSI_LW] | w_sel[LSI_LWU] | w_sel[LSI_SW]) begin
            w_size = SZ_W;
        end else if (w_sel[LSI_LD] | w_sel[LSI_SD]) begin
            w_size = SZ_D;
        end
    end

    always_comb begin
        w_size_misalign = 1'b0;
        w_rep           = i_regdata2;
        w_strb_base     = 8'hFF;
        case (w_size)
            SZ_B: begin
                w_size_misalign = 1'b0;
                w_rep           = {8{i_regdata2[7:0]}};
                w_strb_base     = 8'h01;
            end
            SZ_H: begin
                w_size_misalign = i_addr[0];
                w_rep           = {4{i_regdata2[15:0]}};
                w_strb_base     = 8'h03;
            end
            SZ_W: begin
                w_size_misalign = |i_addr[1:0];
                w_rep           = {2{i_regdata2[31:0]}};
                w_strb_base     = 8'h0F;
            end
            default: begin
                w_size_misalign = |i_addr[2:0];
                w_rep           = i_regdata2;
                w_strb_base     = 8'hFF;
            end
        endcase
    end

    assign o_misalign = o_mem_op & w_size_misalign;
    assign o_wdata    = w_rep << w_shamt;
    assign o_wstrb    = w_strb_base << w_off;

    // The addressed lane is brought down to bit 0 before extension.
    assign w_lane = i_rdata >> w_shamt;

    always_comb begin
        o_load_data = w_lane;
        case (w_size)
            SZ_B:    o_load_data = {{56{w_signed & w_lane[7]}},  w_lane[7:0]};
            SZ_H:    o_load_data = {{48{w_signed & w_lane[15]}}, w_lane[15:0]};
            SZ_W:    o_load_data = {{32{w_signed & w_lane[31]}}, w_lane[31:0]};
            default: o_load_data = w_lane;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access stage: data-cache request FSM, upstream stall, and the
// M/W output register fed from the alignment logic.
module memory_access
    import memory_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     regM_i_pc,
    input  logic [LSI_W-1:0]    regM_i_load_store_info,
    input  logic [OPC_W-1:0]    regM_i_opcode_info,
    input  logic [XLEN-1:0]     regM_i_regdata2,
    input  logic [XLEN-1:0]     regM_i_alu_result,
    input  logic [RD_W-1:0]     regM_i_rd,
    input  logic                regM_i_reg_wen,
    input  logic [COMMIT_W-1:0] regM_i_commit_info,
    output logic                dcache_o_req_valid,
    input  logic                dcache_i_req_ready,
    output logic [XLEN-1:0]     dcache_o_addr,
    output logic                dcache_o_wen,
    output logic [XLEN-1:0]     dcache_o_wdata,
    output logic [7:0]          dcache_o_wstrb,
    input  logic                dcache_i_resp_valid,
    input  logic [XLEN-1:0]     dcache_i_rdata,
    output logic                memory_o_stall,
    output logic                memory_o_valid,
    output logic [XLEN-1:0]     memory_o_wb_data,
    output logic [RD_W-1:0]     memory_o_rd,
    output logic                memory_o_reg_wen,
    output logic [XLEN-1:0]     memory_o_pc,
    output logic [OPC_W-1:0]    memory_o_opcode_info,
    output logic [COMMIT_W-1:0] memory_o_commit_info,
    output logic                memory_o_misalign
);

    // Handshake: a request transfers on a cycle where req_valid and req_ready
    // are both high; payload is held stable until then. One resp_valid pulse
    // per accepted request completes it, and is ignored outside WAIT.

    mem_state_e         r_state;
    mem_state_e         w_state_nxt;
    logic               w_req_valid;
    logic               w_stall;
    logic               w_go;

    logic               w_mem_op;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_misalign;
    logic [XLEN-1:0]    w_wdata;
    logic [7:0]         w_wstrb;
    logic [XLEN-1:0]    w_load_data;
    logic [XLEN-1:0]    w_wb_data;
    logic               w_reg_wen;

    logic               r_valid;
    logic [XLEN-1:0]    r_wb_data;
    logic [RD_W-1:0]    r_rd;
    logic               r_reg_wen;
    logic [XLEN-1:0]    r_pc;
    logic [OPC_W-1:0]   r_opcode_info;
    logic [COMMIT_W-1:0] r_commit_info;
    logic               r_misalign;

    load_store_align u_align (
        .i_lsi       (regM_i_load_store_info),
        .i_addr      (regM_i_alu_result),
        .i_regdata2  (regM_i_regdata2),
        .i_rdata     (dcache_i_rdata),
        .o_mem_op    (w_mem_op),
        .o_is_load   (w_is_load),
        .o_is_store  (w_is_store),
        .o_misalign  (w_misalign),
        .o_wdata     (w_wdata),
        .o_wstrb     (w_wstrb),
        .o_load_data (w_load_data)
    );

    assign w_go = w_mem_op & ~w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_req_valid = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = dcache_i_req_ready ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                w_req_valid = 1'b1;
                w_stall     = 1'b1;
                if (dcache_i_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stall = ~dcache_i_resp_valid;
                if (dcache_i_resp_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Upstream is frozen while stalled, so the combinational payload stays
    // stable through REQ. Reset forces the cache-facing outputs low at once.
    assign dcache_o_req_valid = w_req_valid & ~rst;
    assign memory_o_stall     = w_stall & ~rst;
    assign dcache_o_addr      = rst ? '0 : {regM_i_alu_result[XLEN-1:3], 3'b000};
    assign dcache_o_wen       = w_is_store & ~rst;
    assign dcache_o_wdata     = rst ? '0 : w_wdata;
    assign dcache_o_wstrb     = rst ? '0 : w_wstrb;

    always_comb begin
        w_wb_data = regM_i_alu_result;
        w_reg_wen = regM_i_reg_wen;
        if (w_misalign) begin
            w_wb_data = '0;
            w_reg_wen = 1'b0;
        end else if (w_is_load) begin
            w_wb_data = w_load_data;
        end else if (w_is_store) begin
            w_reg_wen = 1'b0;
        end
    end

    // A bubble is loaded on every stalled edge so each instruction reaches
    // writeback exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_wb_data     <= '0;
            r_rd          <= '0;
            r_reg_wen     <= 1'b0;
            r_pc          <= '0;
            r_opcode_info <= '0;
            r_commit_info <= '0;
            r_misalign    <= 1'b0;
        end else if (w_stall) begin
            r_valid       <= 1'b0;
            r_wb_data     <= '0;
            r_rd          <= '0;
            r_reg_wen     <= 1'b0;
            r_pc          <= '0;
            r_opcode_info <= '0;
            r_commit_info <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_valid       <= 1'b1;
            r_wb_data     <= w_wb_data;
            r_rd          <= regM_i_rd;
            r_reg_wen     <= w_reg_wen;
            r_pc          <= regM_i_pc;
            r_opcode_info <= regM_i_opcode_info;
            r_commit_info <= regM_i_commit_info;
            r_misalign    <= w_misalign;
        end
    end

    assign memory_o_valid       = r_valid;
    assign memory_o_wb_data     = r_wb_data;
    assign memory_o_rd          = r_rd;
    assign memory_o_reg_wen     = r_reg_wen;
    assign memory_o_pc          = r_pc;
    assign memory_o_opcode_info = r_opcode_info;
    assign memory_o_commit_info = r_commit_info;
    assign memory_o_misalign    = r_misalign;

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access: driver issues instructions and plays the
// data cache, a reference model fills the expected queue, a monitor compares.
module tb_memory_access;

    localparam int REC_W = 64 + 5 + 1 + 64 + 12 + 1 + 161;

    logic         clk;
    logic         rst;
    logic [63:0]  regM_i_pc;
    logic [10:0]  regM_i_load_store_info;
    logic [11:0]  regM_i_opcode_info;
    logic [63:0]  regM_i_regdata2;
    logic [63:0]  regM_i_alu_result;
    logic [4:0]   regM_i_rd;
    logic         regM_i_reg_wen;
    logic [160:0] regM_i_commit_info;
    logic         dcache_o_req_valid;
    logic         dcache_i_req_ready;
    logic [63:0]  dcache_o_addr;
    logic         dcache_o_wen;
    logic [63:0]  dcache_o_wdata;
    logic [7:0]   dcache_o_wstrb;
    logic         dcache_i_resp_valid;
    logic [63:0]  dcache_i_rdata;
    logic         memory_o_stall;
    logic         memory_o_valid;
    logic [63:0]  memory_o_wb_data;
    logic [4:0]   memory_o_rd;
    logic         memory_o_reg_wen;
    logic [63:0]  memory_o_pc;
    logic [11:0]  memory_o_opcode_info;
    logic [160:0] memory_o_commit_info;
    logic         memory_o_misalign;

    logic [REC_W-1:0] exp_q[$];
    int n_vec;
    int n_err;
    int n_valid;

    memory_access dut (
        .clk                    (clk),
        .rst                    (rst),
        .regM_i_pc              (regM_i_pc),
        .regM_i_load_store_info (regM_i_load_store_info),
        .regM_i_opcode_info     (regM_i_opcode_info),
        .regM_i_regdata2        (regM_i_regdata2),
        .regM_i_alu_result      (regM_i_alu_result),
        .regM_i_rd              (regM_i_rd),
        .regM_i_reg_wen         (regM_i_reg_wen),
        .regM_i_commit_info     (regM_i_commit_info),
        .dcache_o_req_valid     (dcache_o_req_valid),
        .dcache_i_req_ready     (dcache_i_req_ready),
        .dcache_o_addr          (dcache_o_addr),
        .dcache_o_wen           (dcache_o_wen),
        .dcache_o_wdata         (dcache_o_wdata),
        .dcache_o_wstrb         (dcache_o_wstrb),
        .dcache_i_resp_valid    (dcache_i_resp_valid),
        .dcache_i_rdata         (dcache_i_rdata),
        .memory_o_stall         (memory_o_stall),
        .memory_o_valid         (memory_o_valid),
        .memory_o_wb_data       (memory_o_wb_data),
        .memory_o_rd            (memory_o_rd),
        .memory_o_reg_wen       (memory_o_reg_wen),
        .memory_o_pc            (memory_o_pc),
        .memory_o_opcode_info   (memory_o_opcode_info),
        .memory_o_commit_info   (memory_o_commit_info),
        .memory_o_misalign      (memory_o_misalign)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input int j);
        case (j)
            0, 4, 7: return 1;
            1, 5, 8: return 2;
            2, 6, 9: return 4;
            default: return 8;
        endcase
    endfunction

    task automatic drive_zero();
        regM_i_pc              = '0;
        regM_i_load_store_info = '0;
        regM_i_opcode_info     = '0;
        regM_i_regdata2        = '0;
        regM_i_alu_result      = '0;
        regM_i_rd              = '0;
        regM_i_reg_wen         = 1'b0;
        regM_i_commit_info     = '0;
        dcache_i_req_ready     = 1'b0;
        dcache_i_resp_valid    = 1'b0;
        dcache_i_rdata         = '0;
    endtask

    // Leaving reset with an all-zero instruction retires one all-zero record;
    // a stray response in that first cycle must not disturb it.
    task automatic release_reset();
        @(negedge clk);
        drive_zero();
        dcache_i_resp_valid = 1'b1;
        dcache_i_rdata      = {$urandom, $urandom};
        exp_q.push_back('0);
        rst = 1'b0;
        #1;
        check("post_reset_req_valid", 64'(dcache_o_req_valid), 64'd0);
        check("post_reset_stall", 64'(memory_o_stall), 64'd0);
    endtask

    // ---------------- driver + reference model ----------------
    task automatic do_op(input logic [10:0] lsi, input logic [63:0] addr,
                         input logic [63:0] rd2, input logic [63:0] rdata,
                         input logic [4:0] rd, input logic wen,
                         input int rdy_dly, input int rsp_dly);
        int j, sz, off, total;
        bit is_ld, is_st, sgn, mis, go, exp_rv;
        logic [63:0] lv, msk, wd, exp_wb;
        logic [7:0]  ws;
        logic        exp_wen;
        logic [63:0] pc;
        logic [11:0] opc;
        logic [160:0] cm;
        pc  = {$urandom, $urandom};
        opc = 12'($urandom);
        cm  = 161'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        j = -1;
        for (int b = 10; b >= 0; b--) if (lsi[b]) j = b;
        sz    = size_of(j);
        is_ld = (j >= 0) && (j <= 6);
        is_st = (j >= 7);
        sgn   = (j >= 0) && (j <= 2);
        off   = int'(addr[2:0]);
        mis   = (j >= 0) && ((off % sz) != 0);
        go    = (j >= 0) && !mis;
        msk   = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
        lv    = (rdata >> (8 * off)) & msk;
        if (sgn && lv[8*sz-1]) lv = lv | ~msk;
        wd = '0;
        ws = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= off) wd[8*i +: 8] = 8'(rd2 >> (8 * ((i - off) % sz)));
            ws[i] = (i >= off) && (i < off + sz);
        end
        if (j < 0) begin
            exp_wb = addr; exp_wen = wen;
        end else if (mis) begin
            exp_wb = '0; exp_wen = 1'b0;
        end else if (is_ld) begin
            exp_wb = lv; exp_wen = wen;
        end else begin
            exp_wb = addr; exp_wen = 1'b0;
        end
        exp_q.push_back({exp_wb, rd, exp_wen, pc, opc, mis, cm});
        total = go ? (rdy_dly + rsp_dly + 1) : 1;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            regM_i_pc              = pc;
            regM_i_load_store_info = lsi;
            regM_i_opcode_info     = opc;
            regM_i_regdata2        = rd2;
            regM_i_alu_result      = addr;
            regM_i_rd              = rd;
            regM_i_reg_wen         = wen;
            regM_i_commit_info     = cm;
            if (go) begin
                dcache_i_req_ready  = (c < rdy_dly) ? 1'b0 : ((c == rdy_dly) ? 1'b1 : 1'($urandom));
                dcache_i_resp_valid = (c == total - 1) ? 1'b1 : ((c <= rdy_dly) ? 1'($urandom) : 1'b0);
            end else begin
                dcache_i_req_ready  = 1'($urandom);
                dcache_i_resp_valid = 1'($urandom);
            end
            dcache_i_rdata = (c == total - 1) ? rdata : {$urandom, $urandom};
            #1;
            exp_rv = go && (c <= rdy_dly);
            check("req_valid", 64'(dcache_o_req_valid), 64'(exp_rv));
            check("stall", 64'(memory_o_stall), 64'(go && (c < total - 1)));
            if (exp_rv) begin
                check("req_addr", dcache_o_addr, {addr[63:3], 3'b000});
                check("req_wen", 64'(dcache_o_wen), 64'(is_st));
                if (is_st) begin
                    check("req_wdata", dcache_o_wdata, wd);
                    check("req_wstrb", 64'(dcache_o_wstrb), 64'(ws));
                end
            end
        end
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        regM_i_load_store_info = 11'b000_0000_1000;
        regM_i_alu_result      = 64'h3000;
        regM_i_pc              = 64'h77;
        regM_i_rd              = 5'd3;
        regM_i_reg_wen         = 1'b1;
        dcache_i_req_ready     = 1'b1;
        dcache_i_resp_valid    = 1'b0;
        #1;
        check("rw_accept_stall", 64'(memory_o_stall), 64'd1);
        @(negedge clk);
        dcache_i_req_ready = 1'b0;
        #1;
        check("rw_wait_stall", 64'(memory_o_stall), 64'd1);
        check("rw_wait_req_valid", 64'(dcache_o_req_valid), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_req_valid", 64'(dcache_o_req_valid), 64'd0);
        check("rst_stall", 64'(memory_o_stall), 64'd0);
        check("rst_valid", 64'(memory_o_valid), 64'd0);
        check("rst_addr", dcache_o_addr, 64'd0);
        check("rst_wb_data", memory_o_wb_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        release_reset();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [REC_W-1:0] act_rec;
        logic [REC_W-1:0] exp_rec;
        if (!rst) begin
            act_rec = {memory_o_wb_data, memory_o_rd, memory_o_reg_wen, memory_o_pc,
                       memory_o_opcode_info, memory_o_misalign, memory_o_commit_info};
            n_vec++;
            if (memory_o_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got pc %h wb %h with nothing expected", memory_o_pc, memory_o_wb_data);
                end else begin
                    exp_rec = exp_q.pop_front();
                    if (act_rec !== exp_rec) begin
                        n_err++;
                        $display("FAIL output_record: got %h expected %h", act_rec, exp_rec);
                    end
                end
            end else if (act_rec !== '0) begin
                n_err++;
                $display("FAIL bubble_nonzero: got %h expected 0", act_rec);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int v0, j, sz, r;
        logic [10:0] lsi;
        logic [63:0] addr;
        n_vec = 0; n_err = 0; n_valid = 0;
        rst = 1'b1;
        drive_zero();
        #1;
        check("reset_valid", 64'(memory_o_valid), 64'd0);
        check("reset_wb_data", memory_o_wb_data, 64'd0);
        check("reset_req_valid", 64'(dcache_o_req_valid), 64'd0);
        check("reset_stall", 64'(memory_o_stall), 64'd0);
        repeat (2) @(negedge clk);
        release_reset();

        do_op(11'd0, 64'h1234, 64'd0, 64'd0, 5'd5, 1'b1, 0, 1);
        do_op(11'b000_0000_0001, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 5'd6, 1'b1, 0, 1);
        do_op(11'b000_0001_0000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 5'd7, 1'b1, 0, 1);
        do_op(11'b010_0000_0000, 64'h2004, 64'hDEAD_BEEF, 64'd0, 5'd8, 1'b1, 0, 1);
        v0 = n_valid;
        do_op(11'b000_0000_1000, 64'h4008, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd9, 1'b1, 3, 2);
        do_op(11'd0, 64'h55, 64'd0, 64'd0, 5'd10, 1'b1, 0, 1);
        check("ld_single_output", 64'(n_valid - v0), 64'd2);
        do_op(11'b000_0000_0010, 64'h1001, 64'd0, 64'd0, 5'd11, 1'b1, 0, 1);
        do_op(11'b100_0000_0100, 64'h5004, 64'd0, 64'hF000_0000_0000_0000, 5'd12, 1'b1, 1, 1);
        reset_in_wait();
        do_op(11'd0, 64'h99, 64'd0, 64'd0, 5'd13, 1'b1, 0, 1);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            j = $urandom_range(0, 10);
            lsi = '0;
            if (r >= 3) lsi[j] = 1'b1;
            if (r == 9) lsi = lsi | 11'($urandom);
            j = -1;
            for (int b = 10; b >= 0; b--) if (lsi[b]) j = b;
            sz = size_of(j);
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr[2:0] = 3'(($urandom_range(0, 7) / sz) * sz);
            do_op(lsi, addr, {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(1, 3));
        end

        @(negedge clk);
        #2;
        rst = 1'b1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
